// File: rtl/nway_cache_if.sv
// CPU-side line bus plus memory-side fill/writeback bus of the set-associative cache.
interface nway_cache_if;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] mem_wdata256;
  logic [255:0] mem_rdata256;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256,
           pmem_rdata, pmem_resp,
    output mem_rdata256, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256,
           pmem_rdata, pmem_resp,
    input  mem_rdata256, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/nway_cache.sv
// N-way set-associative write-back/write-allocate cache, 256-bit lines, tree PLRU,
// with its own IDLE/WRITEBACK/ALLOCATE miss controller.
module nway_cache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4
) (
  input  logic        clk,
  input  logic        rst,
  nway_cache_if.slave bus
);
  localparam int s_way    = $clog2(num_ways);
  localparam int s_tag    = 32 - s_offset - s_index;
  localparam int num_sets = 2**s_index;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;
  state_e           state_q, state_d;
  logic [s_way-1:0] victim_q, victim_d;

  logic [num_sets-1:0][num_ways-1:0] valid_q, dirty_q;
  logic [num_sets-1:0][num_ways-2:0] plru_q;
  logic [s_tag-1:0]                  tag_q  [num_sets][num_ways];
  logic [255:0]                      data_q [num_sets][num_ways];

  logic [s_index-1:0]  idx;
  logic [s_tag-1:0]    tag;
  logic                req, hit, hit_now, fill;
  logic [num_ways-1:0] hit_vec, tree, tree_upd;
  logic [s_way-1:0]    hit_way, victim_sel;
  logic [255:0]        merged;
  logic                resp, pread, pwrite;
  logic [31:0]         paddr;
  logic                unused;

  assign idx     = bus.mem_address[s_offset +: s_index];
  assign tag     = bus.mem_address[31 -: s_tag];
  assign req     = bus.mem_read | bus.mem_write;
  assign hit     = |hit_vec;
  assign hit_now = (state_q == IDLE) && req && hit;
  assign fill    = (state_q == ALLOCATE) && bus.pmem_resp;
  assign unused  = ^{bus.mem_address[s_offset-1:0], tree_upd[num_ways-1]};

  for (genvar w = 0; w < num_ways; w++) begin : g_way
    assign hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < num_ways; w++)
      if (hit_vec[w]) hit_way = s_way'(w);
  end

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; bit=1 steers the victim right.
  always_comb begin
    int   node;
    logic b;
    node       = 0;
    b          = 1'b0;
    tree       = {1'b0, plru_q[idx]};
    victim_sel = '0;
    for (int l = 0; l < s_way; l++) begin
      b          = |(tree & (num_ways'(1) << node));
      victim_sel = (victim_sel << 1) | s_way'(b);
      node       = 2 * node + 1 + int'(b);
    end
    for (int w = num_ways - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim_sel = s_way'(w);
    tree_upd = tree;
    node     = 0;
    for (int l = 0; l < s_way; l++) begin
      b = |(hit_way & (s_way'(1) << (s_way - 1 - l)));
      if (b) tree_upd = tree_upd & ~(num_ways'(1) << node);
      else   tree_upd = tree_upd |  (num_ways'(1) << node);
      node = 2 * node + 1 + int'(b);
    end
  end

  always_comb begin
    merged = data_q[idx][hit_way];
    for (int b = 0; b < 32; b++)
      if (bus.mem_byte_enable256[b]) merged[8*b +: 8] = bus.mem_wdata256[8*b +: 8];
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    resp     = 1'b0;
    pread    = 1'b0;
    pwrite   = 1'b0;
    paddr    = {bus.mem_address[31:s_offset], {s_offset{1'b0}}};
    case (state_q)
      IDLE: if (req) begin
        if (hit) resp = 1'b1;
        else begin
          victim_d = victim_sel;
          state_d  = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pwrite = 1'b1;
        paddr  = {tag_q[idx][victim_q], idx, {s_offset{1'b0}}};
        if (bus.pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pread = 1'b1;
        if (bus.pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      plru_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (hit_now) begin
        plru_q[idx] <= tree_upd[num_ways-2:0];
        if (bus.mem_write) dirty_q[idx][hit_way] <= 1'b1;
      end
      if (fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag/data arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (hit_now && bus.mem_write) data_q[idx][hit_way] <= merged;
      if (fill) begin
        data_q[idx][victim_q] <= bus.pmem_rdata;
        tag_q[idx][victim_q]  <= tag;
      end
    end
  end

  assign bus.mem_resp     = resp;
  assign bus.mem_rdata256 = data_q[idx][hit_way];
  assign bus.pmem_read    = pread;
  assign bus.pmem_write   = pwrite;
  assign bus.pmem_address = paddr;
  assign bus.pmem_wdata   = data_q[idx][victim_q];
endmodule

// File: tb/tb_nway_cache.sv
// Directed bench for nway_cache: line-level cache model with recency-based PLRU, checked every cycle.
module tb_nway_cache;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit cfg = 1'b0;  // 0: 4-way/8 sets, 1: 2-way/16 sets
  logic [31:0]  a_addr = '0, a_be = '0;
  logic         a_rd = 1'b0, a_wr = 1'b0, p_resp = 1'b0;
  logic [255:0] a_wd = '0, p_rdata = '0;

  nway_cache_if if4();
  nway_cache_if if2();

  nway_cache #(.s_offset(5), .s_index(3), .num_ways(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  nway_cache #(.s_offset(5), .s_index(4), .num_ways(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  assign if4.mem_address = a_addr;           assign if2.mem_address = a_addr;
  assign if4.mem_read = a_rd && !cfg;        assign if2.mem_read = a_rd && cfg;
  assign if4.mem_write = a_wr && !cfg;       assign if2.mem_write = a_wr && cfg;
  assign if4.mem_byte_enable256 = a_be;      assign if2.mem_byte_enable256 = a_be;
  assign if4.mem_wdata256 = a_wd;            assign if2.mem_wdata256 = a_wd;
  assign if4.pmem_rdata = p_rdata;           assign if2.pmem_rdata = p_rdata;
  assign if4.pmem_resp = p_resp && !cfg;     assign if2.pmem_resp = p_resp && cfg;

  logic         d_resp, d_pr, d_pw;
  logic [31:0]  d_paddr;
  logic [255:0] d_rdata, d_pwd;
  assign d_resp  = cfg ? if2.mem_resp     : if4.mem_resp;
  assign d_pr    = cfg ? if2.pmem_read    : if4.pmem_read;
  assign d_pw    = cfg ? if2.pmem_write   : if4.pmem_write;
  assign d_paddr = cfg ? if2.pmem_address : if4.pmem_address;
  assign d_rdata = cfg ? if2.mem_rdata256 : if4.mem_rdata256;
  assign d_pwd   = cfg ? if2.pmem_wdata   : if4.pmem_wdata;

  // Model: per-set lines keyed by full line address, last-hit timestamps for replacement.
  int           nw = 4, sidx = 3, tstamp = 0;
  bit           m_valid [16][4];
  bit           m_dirty [16][4];
  logic [31:0]  m_line  [16][4];
  logic [255:0] m_data  [16][4];
  int           m_ts    [16][4];
  logic [255:0] pm [logic [31:0]];

  bit           chk_en = 1'b0, e_resp = 1'b0, e_pr = 1'b0, e_pw = 1'b0, e_rdchk = 1'b0;
  logic [31:0]  e_addr = '0;
  logic [255:0] e_wd = '0, e_rd = '0;
  logic [31:0]  lastr = '0, lastw = '0;
  logic [255:0] lastwd = '0, last_rd = '0;
  int           pcnt = 0;

  function automatic logic [255:0] pget(input logic [31:0] a);
    if (pm.exists(a)) return pm[a];
    return {8{a + 32'h1357_0000}};
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 5) & ((32'd1 << sidx) - 32'd1));
  endfunction

  function automatic int lookup(input logic [31:0] a);
    int s, r;
    s = set_of(a);
    r = -1;
    for (int w = 0; w < nw; w++)
      if (m_valid[s][w] && m_line[s][w] == {a[31:5], 5'b0}) r = w;
    return r;
  endfunction

  // Victim: lowest invalid way; otherwise halve the way range repeatedly, moving away from
  // the half that holds the most recently hit way (left when nothing was hit yet).
  function automatic int m_victim(input int s);
    int lo, n, best, bt, r;
    bit found;
    found = 1'b0;
    r = 0;
    for (int w = 0; w < nw; w++)
      if (!found && !m_valid[s][w]) begin found = 1'b1; r = w; end
    if (!found) begin
      lo = 0;
      n  = nw;
      while (n > 1) begin
        best = -1;
        bt   = 0;
        for (int w = lo; w < lo + n; w++)
          if (m_ts[s][w] > bt) begin bt = m_ts[s][w]; best = w; end
        if (best >= 0 && best < lo + n / 2) lo = lo + n / 2;
        n = n / 2;
      end
      r = lo;
    end
    return r;
  endfunction

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("mem_resp", 256'(d_resp), 256'(e_resp));
    chk("pmem_read", 256'(d_pr), 256'(e_pr));
    chk("pmem_write", 256'(d_pw), 256'(e_pw));
    chk("pmem_address", 256'(d_paddr), 256'(e_addr));
    chk("pmem_rd_wr_exclusive", 256'(d_pr & d_pw), 256'(0));
    if (e_pw) chk("pmem_wdata", d_pwd, e_wd);
    if (e_rdchk) chk("mem_rdata256", d_rdata, e_rd);
  end

  always @(negedge clk) begin
    if (d_pr) lastr <= d_paddr;
    if (d_pw) begin lastw <= d_paddr; lastwd <= d_pwd; end
    if (d_resp) last_rd <= d_rdata;
    if (d_pr || d_pw) pcnt <= pcnt + 1;
  end

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; a_rd = 1'b0; a_wr = 1'b0; p_resp = 1'b0;
    a_addr = '0; e_addr = '0; e_resp = 1'b0; e_rdchk = 1'b0;
    cyc();
    rst = 1'b0; e_pr = 1'b0; e_pw = 1'b0;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_ts[s][w] = 0; end
    chk_en = 1'b1;
  endtask

  task automatic access(input logic [31:0] addr, input bit we, input logic [31:0] be, input logic [255:0] wd);
    int s, w, v;
    logic [31:0] line;
    s = set_of(addr);
    line = {addr[31:5], 5'b0};
    w = lookup(addr);
    a_addr = addr; a_rd = !we; a_wr = we; a_be = be; a_wd = wd;
    e_addr = line; e_pr = 1'b0; e_pw = 1'b0; e_resp = 1'b0; e_rdchk = 1'b0;
    if (w < 0) begin
      v = m_victim(s);
      cyc();
      if (m_valid[s][v] && m_dirty[s][v]) begin
        e_pw = 1'b1; e_addr = m_line[s][v]; e_wd = m_data[s][v];
        for (int c = 0; c < LAT; c++) begin p_resp = (c == LAT - 1); cyc(); end
        p_resp = 1'b0; e_pw = 1'b0;
        pm[m_line[s][v]] = m_data[s][v];
      end
      e_pr = 1'b1; e_addr = line; p_rdata = pget(line);
      for (int c = 0; c < LAT; c++) begin p_resp = (c == LAT - 1); cyc(); end
      p_resp = 1'b0; e_pr = 1'b0;
      m_valid[s][v] = 1'b1; m_dirty[s][v] = 1'b0; m_line[s][v] = line; m_data[s][v] = pget(line);
      w = v;
    end
    e_resp = 1'b1; e_rdchk = !we; e_rd = m_data[s][w];
    cyc();
    tstamp++;
    m_ts[s][w] = tstamp;
    if (we) begin
      for (int b = 0; b < 32; b++) if (be[b]) m_data[s][w][8*b +: 8] = wd[8*b +: 8];
      m_dirty[s][w] = 1'b1;
    end
    a_rd = 1'b0; a_wr = 1'b0; e_resp = 1'b0; e_rdchk = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    rst = 1'b1;
    pm[32'h40] = {32{8'hAA}};
    do_reset();
    chk("reset_mem_resp", 256'(d_resp), 256'(0));
    cyc(); cyc();

    access(32'h040, 1'b0, '0, '0);
    chk("fill_addr", 256'(lastr), 256'(32'h40));
    chk("fill_rdata", last_rd, {32{8'hAA}});
    p0 = pcnt;
    access(32'h040, 1'b0, '0, '0);
    chk("hit_no_pmem", 256'(pcnt - p0), 256'(0));

    access(32'h040, 1'b1, 32'h0000_000F, {224'h0, 32'h1122_3344});
    access(32'h040, 1'b0, '0, '0);
    chk("merge_rdata", last_rd, {{28{8'hAA}}, 32'h1122_3344});

    access(32'h140, 1'b0, '0, '0);
    access(32'h240, 1'b0, '0, '0);
    access(32'h340, 1'b0, '0, '0);
    access(32'h040, 1'b0, '0, '0);
    access(32'h240, 1'b0, '0, '0);
    chk("model_victim", 256'(m_victim(2)), 256'(1));
    lastw = '0;
    access(32'h440, 1'b0, '0, '0);
    chk("plru_fill_addr", 256'(lastr), 256'(32'h440));
    chk("clean_no_wb", 256'(lastw), 256'(0));

    access(32'h340, 1'b1, 32'h0000_00F0, {192'h0, 32'hDEAD_BEEF, 32'h0});
    access(32'h240, 1'b0, '0, '0);
    access(32'h040, 1'b0, '0, '0);
    chk("model_victim_dirty", 256'(m_victim(2)), 256'(3));
    access(32'h540, 1'b0, '0, '0);
    chk("wb_addr", 256'(lastw), 256'(32'h340));
    chk("wb_data", lastwd, {{6{32'h1357_0340}}, 32'hDEAD_BEEF, 32'h1357_0340});
    chk("wb_fill_addr", 256'(lastr), 256'(32'h540));

    a_addr = 32'h640; a_rd = 1'b1; e_addr = 32'h640;
    cyc();
    e_pr = 1'b1;
    cyc(); cyc();
    do_reset();
    chk("rst_pread_low", 256'(d_pr), 256'(0));
    cyc();
    lastr = '0;
    access(32'h040, 1'b0, '0, '0);
    chk("after_rst_miss", 256'(lastr), 256'(32'h40));

    cfg = 1'b1; nw = 2; sidx = 4;
    do_reset();
    cyc();
    access(32'h000, 1'b0, '0, '0);
    access(32'h200, 1'b1, 32'hFFFF_FFFF, {8{32'hCAFE_F00D}});
    chk("lru2_victim", 256'(m_victim(0)), 256'(0));
    access(32'h400, 1'b0, '0, '0);
    chk("lru2_evict0", 256'(lastr), 256'(32'h400));
    access(32'h000, 1'b0, '0, '0);
    chk("lru2_wb", 256'(lastw), 256'(32'h200));
    access(32'h200, 1'b0, '0, '0);
    chk("lru2_refill", 256'(lastr), 256'(32'h200));
    chk("lru2_rdata", last_rd, {8{32'hCAFE_F00D}});
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
